// File: rtl/alu_resp_checker.sv
// Checks ALU (a,b,op,y) tuples against an internal model and keeps run statistics.
// 1-cycle check latency; no backpressure: any in_valid seen in RUN is consumed.
module alu_resp_checker #(
   parameter int NUM_TXN = 10,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [3:0]    in_a,
   input  logic [3:0]    in_b,
   input  logic [1:0]    in_op,
   input  logic [7:0]    in_y,
   output logic          busy,
   output logic          done,
   output logic          chk_valid,
   output logic          chk_pass,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic          err_seen,
   output logic [CW-1:0] err_idx,
   output logic [7:0]    err_exp,
   output logic [7:0]    err_got
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] txn_cnt;
   logic [7:0]    exp_y;
   logic          match;
   logic          last_txn;

   always_comb begin
      exp_y = 8'd0;
      case (in_op)
         2'd0: exp_y = {4'd0, in_a} + {4'd0, in_b};
         2'd1: exp_y = {4'd0, in_a} - {4'd0, in_b};
         2'd2: exp_y = {4'd0, in_a} * {4'd0, in_b};
         2'd3: exp_y = {4'd0, in_a & in_b};
         default: exp_y = 8'd0;
      endcase
   end

   assign match    = (exp_y == in_y);
   assign last_txn = (txn_cnt == CW'(NUM_TXN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         txn_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err_seen  <= 1'b0;
         err_idx   <= '0;
         err_exp   <= 8'd0;
         err_got   <= 8'd0;
      end else begin
         chk_valid <= 1'b0;
         if (start) begin
            // start wins over a coincident in_valid, which is dropped
            state    <= ST_RUN;
            txn_cnt  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            chk_pass <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_seen <= 1'b0;
            err_idx  <= '0;
            err_exp  <= 8'd0;
            err_got  <= 8'd0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (in_valid) begin
                     chk_valid <= 1'b1;
                     chk_pass  <= match;
                     txn_cnt   <= txn_cnt + CW'(1);
                     if (match) begin
                        pass_cnt <= pass_cnt + CW'(1);
                     end else begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (!err_seen) begin
                           err_seen <= 1'b1;
                           err_idx  <= txn_cnt;
                           err_exp  <= exp_y;
                           err_got  <= in_y;
                        end
                     end
                     if (last_txn) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               ST_IDLE: state <= ST_IDLE;
               ST_DONE: state <= ST_DONE;
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker with hand-computed tuples and expectations.
module tb_alu_resp_checker;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [3:0]    in_a = '0;
   logic [3:0]    in_b = '0;
   logic [1:0]    in_op = '0;
   logic [7:0]    in_y = '0;
   logic          busy, done, chk_valid, chk_pass, err_seen;
   logic [CW-1:0] pass_cnt, fail_cnt, err_idx;
   logic [7:0]    err_exp, err_got;

   int n_checks = 0;
   int n_fail   = 0;

   // {a, b, op, y}; all tuples correct
   localparam logic [17:0] V1 [10] = '{
      {4'd3,  4'd5,  2'd0, 8'd8},
      {4'd3,  4'd5,  2'd1, 8'd254},
      {4'd9,  4'd9,  2'd2, 8'd81},
      {4'd12, 4'd10, 2'd3, 8'd8},
      {4'd15, 4'd15, 2'd0, 8'd30},
      {4'd0,  4'd1,  2'd1, 8'd255},
      {4'd15, 4'd15, 2'd2, 8'd225},
      {4'd15, 4'd15, 2'd3, 8'd15},
      {4'd7,  4'd2,  2'd2, 8'd14},
      {4'd1,  4'd1,  2'd0, 8'd2}
   };
   // index 3 and 6 carry wrong y
   localparam logic [17:0] V2 [10] = '{
      {4'd3,  4'd5,  2'd0, 8'd8},
      {4'd3,  4'd5,  2'd1, 8'd254},
      {4'd9,  4'd9,  2'd2, 8'd81},
      {4'd7,  4'd2,  2'd2, 8'd15},
      {4'd15, 4'd15, 2'd0, 8'd30},
      {4'd0,  4'd1,  2'd1, 8'd255},
      {4'd1,  4'd1,  2'd0, 8'd0},
      {4'd15, 4'd15, 2'd3, 8'd15},
      {4'd7,  4'd2,  2'd2, 8'd14},
      {4'd1,  4'd1,  2'd0, 8'd2}
   };

   alu_resp_checker #(.NUM_TXN(10), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_y(in_y),
      .busy(busy), .done(done), .chk_valid(chk_valid), .chk_pass(chk_pass),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_seen(err_seen),
      .err_idx(err_idx), .err_exp(err_exp), .err_got(err_got)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " busy"}, {31'd0, busy}, 0);
      check_eq({tag, " done"}, {31'd0, done}, 0);
      check_eq({tag, " chk_valid"}, {31'd0, chk_valid}, 0);
      check_eq({tag, " chk_pass"}, {31'd0, chk_pass}, 0);
      check_eq({tag, " pass_cnt"}, {24'd0, pass_cnt}, 0);
      check_eq({tag, " fail_cnt"}, {24'd0, fail_cnt}, 0);
      check_eq({tag, " err_seen"}, {31'd0, err_seen}, 0);
      check_eq({tag, " err_idx"}, {24'd0, err_idx}, 0);
      check_eq({tag, " err_exp"}, {24'd0, err_exp}, 0);
      check_eq({tag, " err_got"}, {24'd0, err_got}, 0);
   endtask

   // inputs change at posedge+1, outputs sampled at posedge+1 of the following edge
   task automatic apply(input logic [17:0] v, input bit exp_chk, input bit exp_pass);
      in_a = v[17:14]; in_b = v[13:10]; in_op = v[9:8]; in_y = v[7:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("chk_valid", {31'd0, chk_valid}, {31'd0, exp_chk});
      if (exp_chk) check_eq("chk_pass", {31'd0, chk_pass}, {31'd0, exp_pass});
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq({tag, " busy"}, {31'd0, busy}, 1);
      check_eq({tag, " done"}, {31'd0, done}, 0);
      check_eq({tag, " pass_cnt"}, {24'd0, pass_cnt}, 0);
      check_eq({tag, " fail_cnt"}, {24'd0, fail_cnt}, 0);
      check_eq({tag, " err_seen"}, {31'd0, err_seen}, 0);
   endtask

   task automatic check_done(input string tag, input int p, input int f);
      check_eq({tag, " pass_cnt"}, {24'd0, pass_cnt}, p);
      check_eq({tag, " fail_cnt"}, {24'd0, fail_cnt}, f);
      check_eq({tag, " done"}, {31'd0, done}, 1);
      check_eq({tag, " busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: all-correct run
      do_start("t1 start");
      for (int i = 0; i < 10; i++) begin
         apply(V1[i], 1'b1, 1'b1);
         if (i == 8) check_eq("t1 busy before last", {31'd0, busy}, 1);
      end
      in_valid = 1'b0;
      check_done("t1", 10, 0);
      check_eq("t1 err_seen", {31'd0, err_seen}, 0);

      // 2: two mismatches, first one captured
      do_start("t2 start");
      for (int i = 0; i < 10; i++) apply(V2[i], 1'b1, (i != 3) && (i != 6));
      in_valid = 1'b0;
      check_done("t2", 8, 2);
      check_eq("t2 err_seen", {31'd0, err_seen}, 1);
      check_eq("t2 err_idx", {24'd0, err_idx}, 3);
      check_eq("t2 err_exp", {24'd0, err_exp}, 14);
      check_eq("t2 err_got", {24'd0, err_got}, 15);

      // 3: in_valid held for 12 cycles
      do_start("t3 start");
      for (int i = 0; i < 12; i++) begin
         apply(V1[i % 10], i < 10, 1'b1);
         if (i == 9) check_eq("t3 done after 10th", {31'd0, done}, 1);
      end
      in_valid = 1'b0;
      check_done("t3", 10, 0);

      // 4: restart coinciding with in_valid after 4 transactions
      do_start("t4 start");
      for (int i = 0; i < 4; i++) apply(V2[i], 1'b1, i != 3);
      check_eq("t4 fail before restart", {24'd0, fail_cnt}, 1);
      in_a = 4'd3; in_b = 4'd5; in_op = 2'd0; in_y = 8'd8;
      in_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b0;
      check_eq("t4 dropped chk_valid", {31'd0, chk_valid}, 0);
      check_eq("t4 busy", {31'd0, busy}, 1);
      check_eq("t4 pass_cnt", {24'd0, pass_cnt}, 0);
      check_eq("t4 fail_cnt", {24'd0, fail_cnt}, 0);
      check_eq("t4 err_seen", {31'd0, err_seen}, 0);
      check_eq("t4 err_idx", {24'd0, err_idx}, 0);
      check_eq("t4 err_exp", {24'd0, err_exp}, 0);
      check_eq("t4 err_got", {24'd0, err_got}, 0);
      for (int i = 0; i < 9; i++) apply(V1[i], 1'b1, 1'b1);
      in_valid = 1'b0;
      check_eq("t4 not done after 9", {31'd0, done}, 0);
      apply(V1[9], 1'b1, 1'b1);
      in_valid = 1'b0;
      check_done("t4", 10, 0);

      // 5: asynchronous reset mid-run
      do_start("t5 start");
      for (int i = 0; i < 3; i++) apply(V2[i + 2], 1'b1, i != 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5 async reset");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      apply(V1[0], 1'b0, 1'b0);
      in_valid = 1'b0;
      check_eq("t5 idle pass_cnt", {24'd0, pass_cnt}, 0);
      check_eq("t5 idle busy", {31'd0, busy}, 0);
      do_start("t5 restart");
      for (int i = 0; i < 10; i++) apply(V1[i], 1'b1, 1'b1);
      in_valid = 1'b0;
      check_done("t5", 10, 0);

      // 6: in_valid in DONE ignored, then restart
      apply({4'd3, 4'd5, 2'd0, 8'd99}, 1'b0, 1'b0);
      in_valid = 1'b0;
      check_done("t6 hold", 10, 0);
      check_eq("t6 err_seen", {31'd0, err_seen}, 0);
      do_start("t6 start");
      check_eq("t6 err_idx", {24'd0, err_idx}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
